logic_gate_pipe: RTL and testbench
==================================

// Module: logic_gate_pipe
// PURPOSE
//  Parametrised, pipelined, multi-input bitwise logic unit. Generalises the 2-input gate primitives
//  to NUM_IN operands of WIDTH bits with a runtime-selectable operation.
//  Sits between valid/ready stream stages: 2-stage pipeline, full throughput, backpressure-safe.
//  Also provides zero/all-ones result flags, a saturating result counter and a sticky illegal-op flag.
// PARAMETERS
//  WIDTH   8   bit width of each operand and of the result (>=1)
//  NUM_IN  2   number of operands (2..8)
//  CNT_W   16  width of op_count (>=1)
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             asynchronous, active-high reset
//  in_valid   in   1             input transaction valid
//  in_ready   out  1             unit can accept; transfer when in_valid && in_ready
//  in_data    in   NUM_IN*WIDTH  operands; operand k = in_data[k*WIDTH +: WIDTH]
//  op         in   3             operation, sampled with in_data
//  out_valid  out  1             result valid
//  out_ready  in   1             sink accepts; transfer when out_valid && out_ready
//  out_data   out  WIDTH         result
//  out_zero   out  1             out_data == 0; qualified by out_valid
//  out_ones   out  1             out_data == all ones; qualified by out_valid
//  op_count   out  CNT_W         number of completed output transfers, saturating
//  err        out  1             sticky: an op==3'b111 transaction was accepted
// BEHAVIOUR
//  - Reset (async assert, sync release): s1/s2 valid=0; out_data=0; out_zero=0; out_ones=0;
//    op_count=0; err=0. in_ready=1 in the first cycle after release.
//  - Ops (bitwise across all NUM_IN operands): 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR (odd parity),
//    101 XNOR, 110 NOT of operand 0 (others ignored), 111 reserved -> out_data=0 and sets err.
//  - Stage 1 registers operands and op on the input handshake. Stage 2 registers the computed result
//    and flags. Latency: 2 cycles from the accept edge to out_valid, with no stall.
//  - Stage advance: s2 loads when !s2_valid || out_ready. s1 loads when !s1_valid || s1 moves to s2.
//    in_ready = !s1_valid || (s2 can load). Combinational path out_ready -> in_ready is permitted.
//  - When not advancing, a stage holds its data. out_data and flags stay stable while
//    out_valid && !out_ready.
//  - Throughput: 1 transaction/cycle when out_ready=1 continuously. No drop or duplication under
//    any pattern of in_valid and out_ready.
//  - Simultaneous input and output handshakes in the same cycle are legal; both take effect.
//  - op_count += 1 on each output transfer. Holds at 2^CNT_W-1 (saturates, no wrap).
//  - err sets on the accept edge of an op==111 transaction. It is cleared only by rst.
//  - Reset mid-operation: in-flight transactions are discarded. op_count and err clear.
// CONFIGURATION
//  LOGIC_GATE_PIPE_PARITY_EN defined: adds port out_parity (out, 1) = ^out_data, registered in s2
//    alongside out_data, same validity. Reset value 0.
//  Not defined: out_parity port and its logic are absent. All other behaviour is identical.
// TESTING
//  1. WIDTH=8,NUM_IN=2, op=001, in_data={8'h0F,8'hFF}, out_ready=1 -> out_valid 2 cycles later,
//     out_data=8'hF0, out_zero=0, out_ones=0, op_count=1.
//  2. op=000 then 001 with operands {8'h00,8'hFF} -> out_data 8'h00 (out_zero=1), then 8'hFF (out_ones=1).
//  3. Stream 3 txns, out_ready=0 for 5 cycles -> in_ready low after 2 accepts, out_data stable;
//     release -> results in order, op_count=3.
//  4. NUM_IN=4, op=100, operands {8'h01,8'h02,8'h04,8'h08} -> 8'h0F. op=110 -> ~operand0 = 8'hFE.
//  5. op=111 accepted -> out_data=8'h00, err=1 and stays 1 through 50 further legal txns; rst -> err=0.
//  6. CNT_W=4, 20 back-to-back txns -> op_count=15. Async rst mid-stream -> out_valid=0, op_count=0 at once.

Source files
------------

// File: rtl/logic_gate_pipe_if.sv
// Stream interface for logic_gate_pipe: input operand stream, output result
// stream and the status outputs (flags, transfer count, sticky error).
// Optional macro LOGIC_GATE_PIPE_PARITY_EN adds the out_parity signal.
interface logic_gate_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN*WIDTH-1:0]   in_data;
  logic [2:0]                op;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_zero;
  logic                      out_ones;
  logic [CNT_W-1:0]          op_count;
  logic                      err;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  logic                      out_parity;

  // Source/sink side: drives operands and output backpressure
  modport master (
    output in_valid, in_data, op, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_ones, op_count, err, out_parity
  );

  // Logic unit side
  modport slave (
    input  in_valid, in_data, op, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_ones, op_count, err, out_parity
  );
`else
  // Source/sink side: drives operands and output backpressure
  modport master (
    output in_valid, in_data, op, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_ones, op_count, err
  );

  // Logic unit side
  modport slave (
    input  in_valid, in_data, op, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_ones, op_count, err
  );
`endif
endinterface

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage valid/ready pipelined bitwise logic unit over
// NUM_IN operands of WIDTH bits. Stage 1 holds operands and op, stage 2 holds
// the result plus zero/all-ones flags. Also keeps a saturating count of output
// transfers and a sticky flag for the reserved op code.
// Optional macro LOGIC_GATE_PIPE_PARITY_EN adds a registered out_parity output.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  logic_gate_pipe_if.slave  bus
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT0 = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  logic                    s1Valid_q;
  logic [NUM_IN*WIDTH-1:0] s1Data_q;
  logic [2:0]              s1Op_q;
  logic                    s2Valid_q;
  logic [WIDTH-1:0]        s2Data_q;
  logic                    s2Zero_q;
  logic                    s2Ones_q;
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_d;
  logic                    err_q;

  logic [WIDTH-1:0]        andAll;
  logic [WIDTH-1:0]        orAll;
  logic [WIDTH-1:0]        xorAll;
  logic [WIDTH-1:0]        result_d;

  logic                    s2Load;
  logic                    s1Load;
  logic                    inFire;
  logic                    outFire;

  // Stage 2 may take new contents when empty or when its result is leaving.
  // Stage 1 may take new contents when empty or when it can shift forward,
  // which makes in_ready combinationally depend on out_ready.
  assign s2Load  = !s2Valid_q || bus.out_ready;
  assign s1Load  = !s1Valid_q || s2Load;
  assign inFire  = bus.in_valid && s1Load;
  assign outFire = s2Valid_q && bus.out_ready;

  // Reduce all operands held in stage 1 into AND/OR/XOR words
  always_comb begin
    andAll = '1;
    orAll  = '0;
    xorAll = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      andAll = andAll & s1Data_q[k*WIDTH +: WIDTH];
      orAll  = orAll  | s1Data_q[k*WIDTH +: WIDTH];
      xorAll = xorAll ^ s1Data_q[k*WIDTH +: WIDTH];
    end
  end

  // Select the result word for the stage 1 op; the reserved op yields zero
  always_comb begin
    result_d = '0;
    case (s1Op_q)
      OP_AND:  result_d = andAll;
      OP_NAND: result_d = ~andAll;
      OP_OR:   result_d = orAll;
      OP_NOR:  result_d = ~orAll;
      OP_XOR:  result_d = xorAll;
      OP_XNOR: result_d = ~xorAll;
      OP_NOT0: result_d = ~s1Data_q[WIDTH-1:0];
      OP_RSVD: result_d = '0;
      default: result_d = '0;
    endcase
  end

  // Next transfer count, held at all-ones instead of wrapping
  always_comb begin
    count_d = count_q;
    if (outFire && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Stage 1: capture operands and op on each accepted input transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Op_q    <= '0;
    end else if (s1Load) begin
      s1Valid_q <= bus.in_valid;
      if (inFire) begin
        s1Data_q <= bus.in_data;
        s1Op_q   <= bus.op;
      end
    end
  end

  // Stage 2: register result and flags; held steady while the sink stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
      s2Zero_q  <= 1'b0;
      s2Ones_q  <= 1'b0;
    end else if (s2Load) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Data_q <= result_d;
        s2Zero_q <= (result_d == '0);
        s2Ones_q <= (result_d == '1);
      end
    end
  end

  // Count completed output transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Remember that a reserved-op transaction was ever accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (inFire && (bus.op == OP_RSVD)) begin
      err_q <= 1'b1;
    end
  end

`ifdef LOGIC_GATE_PIPE_PARITY_EN
  logic s2Parity_q;

  // Parity of the result, registered alongside stage 2 data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Parity_q <= 1'b0;
    end else if (s2Load && s1Valid_q) begin
      s2Parity_q <= ^result_d;
    end
  end

  assign bus.out_parity = s2Parity_q;
`endif

  assign bus.in_ready  = s1Load;
  assign bus.out_valid = s2Valid_q;
  assign bus.out_data  = s2Data_q;
  assign bus.out_zero  = s2Zero_q;
  assign bus.out_ones  = s2Ones_q;
  assign bus.op_count  = count_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Testbench for logic_gate_pipe (WIDTH=8, NUM_IN=4, CNT_W=4). A behavioural
// model (per-bit ones counting, an in-flight result queue with accept edge
// numbers, a saturating transfer count) is compared against the DUT on every
// falling edge; directed transactions pin literal results.
module tb_logic_gate_pipe;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;
  localparam int CNT_W  = 4;
  localparam int DW     = WIDTH * NUM_IN;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(CNT_W)) bus ();

  logic_gate_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nChecks = 0;
  int nFails  = 0;
  int edgeCnt = 0;

  logic [WIDTH-1:0] expQ[$];
  int               accQ[$];
  int               modelCount = 0;
  logic             modelErr   = 1'b0;

  // Compare one value and report any difference
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference result: per bit, count how many operands have a one there
  function automatic logic [WIDTH-1:0] modelResult(input logic [2:0] op, input logic [DW-1:0] data);
    logic [WIDTH-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int k = 0; k < NUM_IN; k++) begin
        if (data[k*WIDTH + b]) ones++;
      end
      case (op)
        3'd0:    r[b] = (ones == NUM_IN);
        3'd1:    r[b] = (ones != NUM_IN);
        3'd2:    r[b] = (ones > 0);
        3'd3:    r[b] = (ones == 0);
        3'd4:    r[b] = ((ones % 2) == 1);
        3'd5:    r[b] = ((ones % 2) == 0);
        3'd6:    r[b] = !data[b];
        default: r[b] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Number the rising edges so accepted items know when they entered
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Compare process: check DUT against the model, then apply the handshakes
  // that the coming rising edge will perform
  always @(negedge clk) begin
    logic expValid;
    logic expReady;
    if (rst) begin
      expQ.delete();
      accQ.delete();
      modelCount = 0;
      modelErr   = 1'b0;
    end else begin
      expValid = (expQ.size() > 0) && (accQ[0] + 1 <= edgeCnt);
      expReady = (expQ.size() < 2) || bus.out_ready;
      checkOutput("out_valid", bus.out_valid, expValid);
      checkOutput("in_ready", bus.in_ready, expReady);
      if (expValid) begin
        checkOutput("out_data", bus.out_data, expQ[0]);
        checkOutput("out_zero", bus.out_zero, expQ[0] == '0);
        checkOutput("out_ones", bus.out_ones, expQ[0] == '1);
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        checkOutput("out_parity", bus.out_parity, ^expQ[0]);
`endif
      end
      checkOutput("op_count", bus.op_count, modelCount);
      checkOutput("err", bus.err, modelErr);
      if (expValid && bus.out_ready) begin
        void'(expQ.pop_front());
        void'(accQ.pop_front());
        if (modelCount < CNT_MAX) modelCount++;
      end
      if (bus.in_valid && expReady) begin
        expQ.push_back(modelResult(bus.op, bus.in_data));
        accQ.push_back(edgeCnt + 1);
        if (bus.op == 3'b111) modelErr = 1'b1;
      end
    end
  end

  // Drive one cycle's worth of source and sink signals
  task automatic applyStimulus(input logic valid, input logic [2:0] op,
                               input logic [DW-1:0] data, input logic outReady);
    bus.in_valid  = valid;
    bus.op        = op;
    bus.in_data   = data;
    bus.out_ready = outReady;
  endtask

  // Advance one clock; report whether the input handshake happened
  task automatic step(output logic fired);
    @(negedge clk);
    fired = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    logic f;
    applyStimulus(1'b0, 3'd0, '0, 1'b0);
    rst = 1'b1;
    step(f);
    rst = 1'b0;
  endtask

  // One isolated transaction with literal expectations and exact latency
  task automatic runOne(input string name, input logic [2:0] op, input logic [DW-1:0] data,
                        input logic [WIDTH-1:0] expData, input logic expZero, input logic expOnes);
    logic f;
    applyStimulus(1'b1, op, data, 1'b1);
    step(f);
    checkOutput({name, "_accept"}, f, 1'b1);
    checkOutput({name, "_lat1_valid"}, bus.out_valid, 1'b0);
    applyStimulus(1'b0, op, data, 1'b1);
    step(f);
    checkOutput({name, "_lat2_valid"}, bus.out_valid, 1'b1);
    checkOutput({name, "_data"}, bus.out_data, expData);
    checkOutput({name, "_zero"}, bus.out_zero, expZero);
    checkOutput({name, "_ones"}, bus.out_ones, expOnes);
    step(f);
  endtask

  // Random traffic; unaccepted transactions are held until taken
  task automatic randomTraffic(input int cycles, input logic allowRsvd);
    logic f;
    logic curValid;
    logic [2:0] curOp;
    logic [DW-1:0] curData;
    f = 1'b0;
    curValid = 1'b0;
    curOp = '0;
    curData = '0;
    for (int i = 0; i < cycles; i++) begin
      if (!curValid || f) begin
        curValid = ($urandom_range(0, 3) != 0);
        curOp    = 3'($urandom_range(0, allowRsvd ? 7 : 6));
        curData  = DW'($urandom);
      end
      applyStimulus(curValid, curOp, curData, ($urandom_range(0, 2) != 0));
      step(f);
    end
    applyStimulus(1'b0, 3'd0, '0, 1'b1);
    repeat (4) step(f);
  endtask

  initial begin
    logic f;
    int acc;
    int cyc;
    logic [DW-1:0] stallData [3];

    applyStimulus(1'b0, 3'd0, '0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_data", bus.out_data, 8'h00);
    checkOutput("rst_out_zero", bus.out_zero, 1'b0);
    checkOutput("rst_out_ones", bus.out_ones, 1'b0);
    checkOutput("rst_op_count", bus.op_count, 0);
    checkOutput("rst_err", bus.err, 1'b0);
    rst = 1'b0;
    checkOutput("release_in_ready", bus.in_ready, 1'b1);

    // Operand 0 is the lowest byte of in_data
    runOne("nand", 3'b001, {8'hFF, 8'hFF, 8'h0F, 8'hFF}, 8'hF0, 1'b0, 1'b0);
    checkOutput("nand_count", bus.op_count, 1);
    runOne("and_zero", 3'b000, {8'hFF, 8'hFF, 8'hFF, 8'h00}, 8'h00, 1'b1, 1'b0);
    runOne("nand_ones", 3'b001, {8'hFF, 8'hFF, 8'hFF, 8'h00}, 8'hFF, 1'b0, 1'b1);
    runOne("xor4", 3'b100, {8'h08, 8'h04, 8'h02, 8'h01}, 8'h0F, 1'b0, 1'b0);
    runOne("xnor4", 3'b101, {8'h08, 8'h04, 8'h02, 8'h01}, 8'hF0, 1'b0, 1'b0);
    runOne("nor4", 3'b011, {8'h08, 8'h04, 8'h02, 8'h01}, 8'hF0, 1'b0, 1'b0);
    runOne("not0", 3'b110, {8'h08, 8'h04, 8'h02, 8'h01}, 8'hFE, 1'b0, 1'b0);
    checkOutput("err_before_rsvd", bus.err, 1'b0);
    runOne("rsvd", 3'b111, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'h00, 1'b1, 1'b0);
    checkOutput("err_after_rsvd", bus.err, 1'b1);

    // 50 further legal transactions must leave err set
    acc = 0;
    cyc = 0;
    while (acc < 50 && cyc < 500) begin
      applyStimulus(1'b1, 3'($urandom_range(0, 6)), DW'($urandom), ($urandom_range(0, 3) != 0));
      step(f);
      if (f) acc++;
      cyc++;
    end
    checkOutput("legal_accepts", acc, 50);
    applyStimulus(1'b0, 3'd0, '0, 1'b1);
    repeat (3) step(f);
    checkOutput("err_sticky", bus.err, 1'b1);
    doReset();
    checkOutput("err_cleared", bus.err, 1'b0);
    checkOutput("count_cleared", bus.op_count, 0);

    // Backpressure: only two transactions fit while the sink stalls
    stallData[0] = 32'h1111_00FF;
    stallData[1] = 32'h2222_0F0F;
    stallData[2] = 32'h4444_3C3C;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 3'b010, stallData[acc], 1'b0);
      step(f);
      if (f) acc++;
    end
    checkOutput("stall_accepts", acc, 2);
    checkOutput("stall_in_ready", bus.in_ready, 1'b0);
    checkOutput("stall_out_data", bus.out_data, 8'hFF);
    cyc = 0;
    while (acc < 3 && cyc < 10) begin
      applyStimulus(1'b1, 3'b010, stallData[acc], 1'b1);
      step(f);
      if (f) acc++;
      cyc++;
    end
    checkOutput("release_accepts", acc, 3);
    applyStimulus(1'b0, 3'd0, '0, 1'b1);
    repeat (4) step(f);
    checkOutput("stall_count", bus.op_count, 3);

    // Saturation: 20 back-to-back transfers with a 4-bit count
    doReset();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 3'($urandom_range(0, 6)), DW'($urandom), 1'b1);
      step(f);
      if (f) acc++;
    end
    checkOutput("b2b_accepts", acc, 20);
    applyStimulus(1'b0, 3'd0, '0, 1'b1);
    repeat (3) step(f);
    checkOutput("count_saturated", bus.op_count, CNT_MAX);

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'b111, DW'($urandom), 1'b1);
      step(f);
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", bus.out_valid, 1'b0);
    checkOutput("async_rst_count", bus.op_count, 0);
    checkOutput("async_rst_err", bus.err, 1'b0);
    applyStimulus(1'b0, 3'd0, '0, 1'b0);
    step(f);
    rst = 1'b0;

    // Random valid/ready traffic including the reserved op
    randomTraffic(600, 1'b1);
    doReset();
    randomTraffic(300, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
